// File: rtl/servcle_pkg.sv
// Shared servcle ring definitions: station state encoding and the round-robin search.
package servcle_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int RR_MAX = 64;
    localparam int RR_IW  = 6;

    // First set bit of req[nch-1:0] found by scanning upward from base with wrap; 0 if none.
    function automatic int rr_pick(input logic [RR_MAX-1:0] req, input int base, input int nch);
        int   idx;
        logic found;
        rr_pick = 0;
        found   = 1'b0;
        for (int i = 0; i < RR_MAX; i++) begin
            idx = (base + i) % nch;
            if (!found && (i < nch) && req[idx[RR_IW-1:0]]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/servcle_rr_arb.sv
// Combinational round-robin picker: masked request vector, search base, chosen index and any flag.
module servcle_rr_arb #(
    parameter int NCH = 4,
    parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req_i,
    input  logic [IW-1:0]  base_i,
    input  logic [NCH-1:0] excl_i,
    output logic [IW-1:0]  idx_o,
    output logic           any_o
);
    import servcle_pkg::*;

    logic [RR_MAX-1:0] req_ext;

    always_comb begin
        req_ext            = '0;
        req_ext[NCH-1:0]   = req_i & ~excl_i;
        any_o              = |req_ext;
        idx_o              = IW'(rr_pick(req_ext, int'(base_i), NCH));
    end

endmodule

// File: rtl/servcle_mentry.sv
// Multi-channel token-ring entry station: forwards ring traffic while idle and, while holding
// the token, sends whole frames from its local channels in round-robin order.
module servcle_mentry #(
    parameter int   DW         = 8,
    parameter int   NCH        = 4,
    parameter int   MAX_FRAMES = 1,
    parameter logic TOKEN_INIT = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NCH*DW-1:0] i_reg_data,
    input  logic [NCH-1:0]    i_reg_last,
    input  logic [NCH-1:0]    i_reg_valid,
    output logic [NCH-1:0]    o_reg_ready,
    input  logic [DW-1:0]     i_data,
    input  logic              i_valid,
    input  logic              i_token,
    output logic [DW-1:0]     o_data,
    output logic              o_valid,
    output logic              o_token
);
    import servcle_pkg::*;

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int FW = $clog2(MAX_FRAMES + 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic            valid_q, valid_d;
    logic            token_q, token_d;
    logic [DW-1:0]   data_q, data_d;

    logic [DW-1:0]   ch_data [NCH];
    logic [IW-1:0]   gnt_nxt;
    logic [NCH-1:0]  gnt_oh;
    logic [IW-1:0]   arb_base;
    logic [NCH-1:0]  arb_excl;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic            gnt_vld;
    logic            take_last;

    for (genvar k = 0; k < NCH; k++) begin : g_unpack
        assign ch_data[k] = i_reg_data[k*DW +: DW];
    end

    assign gnt_oh  = NCH'(1) << gnt_q;
    assign gnt_nxt = (gnt_q == IW'(NCH - 1)) ? '0 : gnt_q + 1'b1;

    // Idle: grant search starts at rr. Holding: successor search starts after gnt and skips it,
    // so a clear any flag also means nobody else is waiting.
    assign arb_base = (state_q == HOLD) ? gnt_nxt : rr_q;
    assign arb_excl = (state_q == HOLD) ? gnt_oh : '0;

    servcle_rr_arb #(
        .NCH (NCH),
        .IW  (IW)
    ) u_arb (
        .req_i  (i_reg_valid),
        .base_i (arb_base),
        .excl_i (arb_excl),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

    assign o_reg_ready = (state_q == HOLD) ? gnt_oh : '0;
    assign gnt_vld     = i_reg_valid[gnt_q];
    assign take_last   = (state_q == HOLD) && gnt_vld && i_reg_last[gnt_q];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        fcnt_d  = fcnt_q;
        valid_d = 1'b0;
        data_d  = data_q;
        token_d = 1'b0;
        case (state_q)
            IDLE: begin
                valid_d = i_valid;
                data_d  = i_data;
                if (i_token) begin
                    if (arb_any) begin
                        gnt_d   = arb_idx;
                        fcnt_d  = '0;
                        state_d = HOLD;
                    end else begin
                        token_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                valid_d = gnt_vld;
                if (gnt_vld) begin
                    data_d = ch_data[gnt_q];
                end
                if (take_last) begin
                    rr_d   = gnt_nxt;
                    fcnt_d = fcnt_q + 1'b1;
                    if ((fcnt_q + 1'b1 == FW'(MAX_FRAMES)) || !arb_any) begin
                        token_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        gnt_d = arb_idx;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            fcnt_q  <= '0;
            valid_q <= 1'b0;
            token_q <= TOKEN_INIT;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            fcnt_q  <= fcnt_d;
            valid_q <= valid_d;
            token_q <= token_d;
        end
    end

    // Ring data is qualified by o_valid, so it carries no reset.
    always_ff @(posedge i_clk) begin
        data_q <= data_d;
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_token = token_q;

    a_no_token_in_hold: assert property (@(posedge i_clk) disable iff (i_rst)
        !((state_q == HOLD) && i_token));

endmodule

// File: tb/tb_servcle_mentry.sv
// Bench for servcle_mentry: two stations (MAX_FRAMES 1 and 3) exercised by vector tables,
// directed multi-cycle sequences and random traffic against a frame-level reference model.
module tb_servcle_mentry;

    localparam int DW  = 8;
    localparam int NCH = 4;
    localparam bit A   = 1'b0;
    localparam bit B   = 1'b1;

    logic              clk = 1'b0;
    logic              rst    [2];
    logic [NCH*DW-1:0] rdata  [2];
    logic [NCH-1:0]    rlast  [2];
    logic [NCH-1:0]    rvalid [2];
    logic [NCH-1:0]    rready [2];
    logic [DW-1:0]     idata  [2];
    logic [DW-1:0]     odata  [2];
    logic              ivalid [2];
    logic              itoken [2];
    logic              ovalid [2];
    logic              otoken [2];

    int n_cmp = 0;
    int n_bad = 0;

    bit   m_hold [2];
    int   m_gnt  [2];
    int   m_rr   [2];
    int   m_cnt  [2];
    int   m_max  [2] = '{1, 3};
    logic m_init [2] = '{1'b0, 1'b1};

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       tk;
        logic [3:0] rv;
        logic       ev;
        logic [7:0] ed;
        logic       et;
    } vec_t;

    always #5 clk = ~clk;

    servcle_mentry #(.DW(DW), .NCH(NCH), .MAX_FRAMES(1), .TOKEN_INIT(1'b0)) dut_a (
        .i_clk(clk), .i_rst(rst[0]), .i_reg_data(rdata[0]), .i_reg_last(rlast[0]),
        .i_reg_valid(rvalid[0]), .o_reg_ready(rready[0]), .i_data(idata[0]),
        .i_valid(ivalid[0]), .i_token(itoken[0]), .o_data(odata[0]), .o_valid(ovalid[0]),
        .o_token(otoken[0]));

    servcle_mentry #(.DW(DW), .NCH(NCH), .MAX_FRAMES(3), .TOKEN_INIT(1'b1)) dut_b (
        .i_clk(clk), .i_rst(rst[1]), .i_reg_data(rdata[1]), .i_reg_last(rlast[1]),
        .i_reg_valid(rvalid[1]), .o_reg_ready(rready[1]), .i_data(idata[1]),
        .i_valid(ivalid[1]), .i_token(itoken[1]), .o_data(odata[1]), .o_valid(ovalid[1]),
        .o_token(otoken[1]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_idle(input bit u);
        rdata[u]  = '0;
        rlast[u]  = '0;
        rvalid[u] = '0;
        idata[u]  = '0;
        ivalid[u] = 1'b0;
        itoken[u] = 1'b0;
    endtask

    task automatic set_ch(input bit u, input logic [1:0] k, input logic v, input logic [7:0] d,
                          input logic l);
        rvalid[u][k]       = v;
        rdata[u][k*8 +: 8] = d;
        rlast[u][k]        = l;
    endtask

    task automatic mreset(input bit u);
        m_hold[u] = 1'b0;
        m_gnt[u]  = 0;
        m_rr[u]   = 0;
        m_cnt[u]  = 0;
    endtask

    task automatic reset_dut(input bit u);
        set_idle(u);
        rst[u] = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(ovalid[u]), 32'd0);
        chk("rst_token", 32'(otoken[u]), 32'(m_init[u]));
        chk("rst_ready", 32'(rready[u]), 32'd0);
        rst[u] = 1'b0;
        mreset(u);
    endtask

    function automatic int first_req(input logic [3:0] req, input int base);
        for (int i = 0; i < 4; i++) begin
            if (req[2'((base + i) % 4)]) return (base + i) % 4;
        end
        return -1;
    endfunction

    // One clock of station behaviour, from the current inputs and the model's hold bookkeeping.
    task automatic model_step(input bit u, output bit ev, output logic [7:0] ed, output bit et);
        logic [3:0] vld;
        int g, nx;
        vld = rvalid[u];
        ev  = 1'b0;
        ed  = '0;
        et  = 1'b0;
        if (!m_hold[u]) begin
            ev = ivalid[u];
            ed = idata[u];
            if (itoken[u]) begin
                nx = first_req(vld, m_rr[u]);
                if (nx >= 0) begin
                    m_hold[u] = 1'b1;
                    m_gnt[u]  = nx;
                    m_cnt[u]  = 0;
                end else begin
                    et = 1'b1;
                end
            end
        end else begin
            g  = m_gnt[u];
            ev = vld[2'(g)];
            ed = rdata[u][g*8 +: 8];
            if (vld[2'(g)] && rlast[u][2'(g)]) begin
                m_rr[u]  = (g + 1) % 4;
                m_cnt[u] = m_cnt[u] + 1;
                vld[2'(g)] = 1'b0;
                nx = first_req(vld, g + 1);
                if (m_cnt[u] == m_max[u] || nx < 0) begin
                    et        = 1'b1;
                    m_hold[u] = 1'b0;
                end else begin
                    m_gnt[u] = nx;
                end
            end
        end
    endtask

    task automatic test_table();
        vec_t tbl [6];
        tbl[0] = '{1'b1, 8'h5A, 1'b0, 4'h0, 1'b1, 8'h5A, 1'b0};
        tbl[1] = '{1'b0, 8'h33, 1'b1, 4'h0, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{1'b1, 8'hFF, 1'b0, 4'hF, 1'b1, 8'hFF, 1'b0};
        tbl[3] = '{1'b1, 8'h00, 1'b1, 4'h0, 1'b1, 8'h00, 1'b1};
        tbl[4] = '{1'b0, 8'hA5, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{1'b1, 8'hC3, 1'b0, 4'h5, 1'b1, 8'hC3, 1'b0};
        reset_dut(A);
        for (int i = 0; i < 6; i++) begin
            ivalid[A] = tbl[i].iv;
            idata[A]  = tbl[i].id;
            itoken[A] = tbl[i].tk;
            rvalid[A] = tbl[i].rv;
            step();
            chk("tbl_valid", 32'(ovalid[A]), 32'(tbl[i].ev));
            chk("tbl_token", 32'(otoken[A]), 32'(tbl[i].et));
            chk("tbl_ready", 32'(rready[A]), 32'd0);
            if (tbl[i].ev) chk("tbl_data", 32'(odata[A]), 32'(tbl[i].ed));
        end
        set_idle(A);
    endtask

    task automatic test_single();
        logic [7:0] w [3];
        w = '{8'h11, 8'h22, 8'h33};
        reset_dut(A);
        set_ch(A, 2'd2, 1'b1, w[0], 1'b0);
        itoken[A] = 1'b1;
        step();
        chk("sf_ready0", 32'(rready[A]), 32'h4);
        chk("sf_token0", 32'(otoken[A]), 32'd0);
        chk("sf_valid0", 32'(ovalid[A]), 32'd0);
        itoken[A] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_ch(A, 2'd2, 1'b1, w[i], i == 2);
            step();
            chk("sf_valid", 32'(ovalid[A]), 32'd1);
            chk("sf_data", 32'(odata[A]), 32'(w[i]));
            chk("sf_token", 32'(otoken[A]), 32'(i == 2));
            chk("sf_ready", 32'(rready[A]), (i == 2) ? 32'h0 : 32'h4);
        end
        set_idle(A);
        step();
        chk("sf_token_after", 32'(otoken[A]), 32'd0);
    endtask

    task automatic test_fair();
        reset_dut(A);
        for (int k = 0; k < 4; k++) set_ch(A, 2'(k), 1'b1, 8'(8'h10 + k), 1'b1);
        for (int v = 0; v < 8; v++) begin
            itoken[A] = 1'b1;
            step();
            chk("rr_ready", 32'(rready[A]), 32'(1 << (v % 4)));
            itoken[A] = 1'b0;
            step();
            chk("rr_data", 32'(odata[A]), 32'(8'h10 + v % 4));
            chk("rr_token", 32'(otoken[A]), 32'd1);
        end
        set_idle(A);
    endtask

    task automatic test_stall();
        reset_dut(A);
        set_ch(A, 2'd1, 1'b1, 8'hA1, 1'b0);
        itoken[A] = 1'b1;
        step();
        chk("st_ready0", 32'(rready[A]), 32'h2);
        itoken[A] = 1'b0;
        step();
        chk("st_data1", 32'(odata[A]), 32'hA1);
        for (int s = 0; s < 5; s++) begin
            set_ch(A, 2'd1, 1'b0, 8'hEE, 1'b0);
            step();
            chk("st_valid", 32'(ovalid[A]), 32'd0);
            chk("st_hold_data", 32'(odata[A]), 32'hA1);
            chk("st_token", 32'(otoken[A]), 32'd0);
            chk("st_ready", 32'(rready[A]), 32'h2);
        end
        set_ch(A, 2'd1, 1'b1, 8'hA2, 1'b0);
        step();
        chk("st_data2", 32'(odata[A]), 32'hA2);
        chk("st_token2", 32'(otoken[A]), 32'd0);
        set_ch(A, 2'd1, 1'b1, 8'hA3, 1'b1);
        step();
        chk("st_data3", 32'(odata[A]), 32'hA3);
        chk("st_token3", 32'(otoken[A]), 32'd1);
        chk("st_ready3", 32'(rready[A]), 32'd0);
        set_idle(A);
    endtask

    task automatic test_multi();
        int         wi [4];
        logic [7:0] got_d [$];
        int         got_c [$];
        int         tok_n, tok_c;
        logic [3:0] rdy, vv;
        logic [7:0] mf_exp [6];
        mf_exp = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h30, 8'h31};
        tok_n  = 0;
        tok_c  = -1;
        for (int k = 0; k < 4; k++) wi[k] = 0;
        reset_dut(B);
        for (int cyc = 0; cyc < 12; cyc++) begin
            for (int k = 0; k < 4; k++) begin
                if (k != 2 && wi[k] < 2) set_ch(B, 2'(k), 1'b1, 8'(k * 16 + wi[k]), wi[k] == 1);
                else set_ch(B, 2'(k), 1'b0, 8'h00, 1'b0);
            end
            itoken[B] = (cyc == 0);
            rdy = rready[B];
            vv  = rvalid[B];
            step();
            for (int k = 0; k < 4; k++) if (rdy[k] && vv[k]) wi[k]++;
            if (ovalid[B]) begin
                got_d.push_back(odata[B]);
                got_c.push_back(cyc);
            end
            if (otoken[B]) begin
                tok_n++;
                tok_c = cyc;
            end
        end
        chk("mf_count", 32'(got_d.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk("mf_word", (i < got_d.size()) ? 32'(got_d[i]) : 32'hDEAD, 32'(mf_exp[i]));
            chk("mf_contig", (i < got_c.size()) ? 32'(got_c[i] - got_c[0]) : 32'hDEAD, 32'(i));
        end
        chk("mf_tok_n", 32'(tok_n), 32'd1);
        chk("mf_tok_cyc", 32'(tok_c), (got_c.size() > 0) ? 32'(got_c[got_c.size() - 1]) : 32'hDEAD);
        set_idle(B);
    endtask

    task automatic test_rst_mid();
        reset_dut(B);
        set_ch(B, 2'd2, 1'b1, 8'h55, 1'b1);
        itoken[B] = 1'b1;
        step();
        chk("rm_ready2", 32'(rready[B]), 32'h4);
        itoken[B] = 1'b0;
        step();
        chk("rm_data2", 32'(odata[B]), 32'h55);
        chk("rm_token2", 32'(otoken[B]), 32'd1);
        set_ch(B, 2'd2, 1'b0, 8'h00, 1'b0);
        set_ch(B, 2'd3, 1'b1, 8'h61, 1'b0);
        itoken[B] = 1'b1;
        step();
        chk("rm_ready3", 32'(rready[B]), 32'h8);
        itoken[B] = 1'b0;
        step();
        chk("rm_data3", 32'(odata[B]), 32'h61);
        set_ch(B, 2'd3, 1'b1, 8'h62, 1'b0);
        rst[B] = 1'b1;
        step();
        chk("rm_valid", 32'(ovalid[B]), 32'd0);
        chk("rm_ready", 32'(rready[B]), 32'd0);
        chk("rm_token", 32'(otoken[B]), 32'd1);
        rst[B] = 1'b0;
        for (int k = 0; k < 4; k++) set_ch(B, 2'(k), 1'b1, 8'(k), 1'b0);
        ivalid[B] = 1'b1;
        idata[B]  = 8'h77;
        step();
        chk("rm_fwd_valid", 32'(ovalid[B]), 32'd1);
        chk("rm_fwd_data", 32'(odata[B]), 32'h77);
        ivalid[B] = 1'b0;
        itoken[B] = 1'b1;
        step();
        chk("rm_rr_base", 32'(rready[B]), 32'h1);
        set_idle(B);
    endtask

    task automatic run_random(input bit u, input int ncyc);
        bit         ev, et;
        logic [7:0] ed;
        logic [3:0] lst;
        logic [3:0] er;
        reset_dut(u);
        for (int c = 0; c < ncyc; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst[u] = 1'b1;
                step();
                mreset(u);
                chk("rnd_rst_valid", 32'(ovalid[u]), 32'd0);
                chk("rnd_rst_token", 32'(otoken[u]), 32'(m_init[u]));
                rst[u] = 1'b0;
                continue;
            end
            for (int k = 0; k < 4; k++) lst[k] = ($urandom_range(0, 2) == 0);
            rvalid[u] = 4'($urandom);
            rlast[u]  = lst;
            rdata[u]  = $urandom;
            ivalid[u] = 1'($urandom);
            idata[u]  = 8'($urandom);
            itoken[u] = !m_hold[u] && ($urandom_range(0, 3) == 0);
            model_step(u, ev, ed, et);
            step();
            er = m_hold[u] ? 4'(1 << m_gnt[u]) : 4'h0;
            chk("rnd_ready", 32'(rready[u]), 32'(er));
            chk("rnd_valid", 32'(ovalid[u]), 32'(ev));
            chk("rnd_token", 32'(otoken[u]), 32'(et));
            if (ev) chk("rnd_data", 32'(odata[u]), 32'(ed));
        end
        set_idle(u);
        step();
    endtask

    initial begin
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        set_idle(A);
        set_idle(B);
        reset_dut(B);
        test_table();
        test_single();
        test_fair();
        test_stall();
        test_multi();
        test_rst_mid();
        run_random(A, 1500);
        run_random(B, 1500);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
